exe_alu_stage: RTL and testbench
================================

Name: exe_alu_stage

Overview:
- Execute stage of the multi-cycle CPU; sits directly downstream of the decode stage.
- Consumes the decode-stage registers regAOut, regBOut and expBitOut, plus the current PC.
- Selects ALU operands, executes single-cycle ALU ops, and runs a 32-step iterative unsigned multiply.
- Holds results in the ALUOut, zero-flag and HI/LO registers for the memory/write-back stages.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.
- MUL_STEPS, 32, number of shift-add iterations for MULU. Must equal WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pcOut  input  32  current PC value.
- regAOut  input  32  decode-stage A register.
- regBOut  input  32  decode-stage B register.
- expBitOut  input  32  decode-stage sign-extended immediate.
- aluSrcA  input  1  operand A select: 0 = pcOut, 1 = regAOut.
- aluSrcB  input  2  operand B select: 0 = regBOut, 1 = 32'd4, 2 = expBitOut, 3 = expBitOut<<2.
- aluOp  input  4  operation code; see Behaviour.
- aluEn  input  1  start request, one cycle, sampled on clock edges.
- aluOut  output  32  registered result.
- zeroFlag  output  1  registered; 1 iff the last single-cycle result was 0.
- hiOut  output  32  registered upper 32 bits of the last MULU product.
- loOut  output  32  registered lower 32 bits of the last MULU product.
- busy  output  1  high while a MULU is in progress.
- done  output  1  one-cycle pulse when a result becomes valid.

Behaviour:
- Reset: synchronous; on any edge with rst=1, aluOut, hiOut, loOut = 0, zeroFlag = 0, busy = 0, done = 0, state = IDLE, step counter = 0.
- rst=1 mid-MULU aborts the multiply, clears all state, and produces no done pulse.
- Operands: opA and opB come from the muxes, combinational from current inputs, and are used at the edge that accepts aluEn.
- Single-cycle op codes:
  - 0 ADD, 1 SUB: both wrap modulo 2^32, no overflow trap.
  - 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT: signed compare, result 1/0.
  - 7 SLTU: unsigned compare, result 1/0.
  - 8 SLL, 9 SRL, 10 SRA: shift opB by opA[4:0].
  - 11 LUI: opB<<16.
  - 13-15: result 0.
- Multi-cycle op code: 12 MULU, unsigned 32x32 -> 64.
- State machine has two states, IDLE and MUL.
- IDLE, aluEn=1, single-cycle op:
  - At that edge, aluOut = result and zeroFlag = (result == 0).
  - done = 1 for the following cycle.
  - State stays IDLE.
  - Back-to-back aluEn on consecutive cycles is allowed; each produces one done.
- IDLE, aluEn=1, op 12:
  - Latch multiplicand = opA and multiplier = opB, clear the 64-bit accumulator, counter = 0.
  - Go to MUL; busy = 1 from the next cycle.
- MUL, each edge:
  - If multiplier[0], accumulator[63:32] += multiplicand, keeping the carry into a 33rd bit.
  - Shift {carry, accumulator} right by 1, shift the multiplier right by 1, counter++.
  - At the edge where counter reaches MUL_STEPS-1 (the 32nd step):
    - hiOut = product[63:32], loOut = product[31:0], aluOut = product[31:0].
    - zeroFlag is unchanged.
    - busy = 0 and done = 1 for the following cycle; state returns to IDLE.
- MULU latency: aluEn edge E0, busy high after E0 through E32, done high for the cycle after E32. Total 33 edges.
- aluEn while busy is ignored: no state or operand change, no queued request.
- aluEn in the same cycle as a done pulse (state IDLE) is accepted normally.
- Outputs hold their values between operations.
- hiOut and loOut change only on MULU completion or reset.

Test Plan:
- Reset: assert rst for 2 edges with aluEn=1 -> aluOut=0, hiOut=0, loOut=0, zeroFlag=0, busy=0, done=0.
- ADD: aluSrcA=0, pcOut=0x00000100, aluSrcB=3, expBitOut=0xFFFFFFFF -> aluOut=0x000000FC one cycle after aluEn, done pulse width 1, zeroFlag=0.
- SUB and compares:
  - SUB regAOut=regBOut=0x12345678 -> aluOut=0, zeroFlag=1.
  - SLT A=0xFFFFFFFF, B=1 -> aluOut=1.
  - SLTU with the same operands -> aluOut=0.
- Shifts: SRA B=0x80000000, A[4:0]=4 -> aluOut=0xF8000000; SLL B=1, A=31 -> aluOut=0x80000000.
- MULU corner case: A=B=0xFFFFFFFF -> busy high 32 cycles, then hiOut=0xFFFFFFFE, loOut=0x00000001, aluOut=0x00000001, done one cycle, zeroFlag unchanged.
- Busy and abort:
  - MULU 3x5 with a second aluEn (ADD) issued mid-busy -> ignored; loOut=15, hiOut=0; aluOut stays 15 after done.
  - Separate run: rst at step 10 of a MULU -> all outputs 0 next cycle, no done.

Source files
------------

// File: rtl/exe_alu_stage.sv
// Execute stage: operand muxing, single-cycle ALU, and a 32-step shift-add unsigned multiply.
// Results are held in ALUOut/zero/HI/LO registers for the downstream memory and write-back stages.
`timescale 1ns/1ps
module exe_alu_stage #(
   parameter int WIDTH     = 32,
   parameter int MUL_STEPS = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pcOut,
   input  logic [WIDTH-1:0] regAOut,
   input  logic [WIDTH-1:0] regBOut,
   input  logic [WIDTH-1:0] expBitOut,
   input  logic             aluSrcA,
   input  logic [1:0]       aluSrcB,
   input  logic [3:0]       aluOp,
   input  logic             aluEn,
   output logic [WIDTH-1:0] aluOut,
   output logic             zeroFlag,
   output logic [WIDTH-1:0] hiOut,
   output logic [WIDTH-1:0] loOut,
   output logic             busy,
   output logic             done
);

   localparam int              CNT_W     = $clog2(MUL_STEPS);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);
   localparam logic [3:0]      OP_MULU   = 4'd12;
   localparam logic [0:0]      S_IDLE    = 1'b0;
   localparam logic [0:0]      S_MUL     = 1'b1;

   function automatic logic [WIDTH-1:0] alu_calc(input logic [3:0]       op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      logic signed [WIDTH-1:0] sa;
      logic signed [WIDTH-1:0] sb;
      logic [4:0]              sh;
      sa = a;
      sb = b;
      sh = a[4:0];
      case (op)
         4'd0:    alu_calc = a + b;
         4'd1:    alu_calc = a - b;
         4'd2:    alu_calc = a & b;
         4'd3:    alu_calc = a | b;
         4'd4:    alu_calc = a ^ b;
         4'd5:    alu_calc = ~(a | b);
         4'd6:    alu_calc = (sa < sb) ? WIDTH'(1) : '0;
         4'd7:    alu_calc = (a < b) ? WIDTH'(1) : '0;
         4'd8:    alu_calc = b << sh;
         4'd9:    alu_calc = b >> sh;
         4'd10:   alu_calc = WIDTH'(sb >>> sh);
         4'd11:   alu_calc = b << 16;
         default: alu_calc = '0;
      endcase
   endfunction

   logic [0:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   alu_out_q, alu_out_d;
   logic               zero_q, zero_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [WIDTH-1:0]   alu_res;
   logic [WIDTH:0]     add_sum;
   logic [2*WIDTH-1:0] acc_next;

   always_comb begin
      op_a = aluSrcA ? regAOut : pcOut;
      case (aluSrcB)
         2'd0:    op_b = regBOut;
         2'd1:    op_b = WIDTH'(4);
         2'd2:    op_b = expBitOut;
         default: op_b = expBitOut << 2;
      endcase
      alu_res = alu_calc(aluOp, op_a, op_b);
   end

   // One shift-add step: the 33rd sum bit carries into the top of the shifted accumulator.
   always_comb begin
      if (mplier_q[0])
         add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
      else
         add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      acc_next = {add_sum, acc_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      alu_out_d = alu_out_q;
      zero_d    = zero_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (aluEn) begin
               if (aluOp == OP_MULU) begin
                  mcand_d  = op_a;
                  mplier_d = op_b;
                  acc_d    = '0;
                  cnt_d    = '0;
                  state_d  = S_MUL;
               end else begin
                  alu_out_d = alu_res;
                  zero_d    = (alu_res == '0);
                  done_d    = 1'b1;
               end
            end
         end
         S_MUL: begin
            acc_d    = acc_next;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            // aluEn is deliberately not looked at here: requests while busy are dropped.
            if (cnt_q == LAST_STEP) begin
               hi_d      = acc_next[2*WIDTH-1:WIDTH];
               lo_d      = acc_next[WIDTH-1:0];
               alu_out_d = acc_next[WIDTH-1:0];
               done_d    = 1'b1;
               state_d   = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         alu_out_q <= '0;
         zero_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         alu_out_q <= alu_out_d;
         zero_q    <= zero_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign aluOut   = alu_out_q;
   assign zeroFlag = zero_q;
   assign hiOut    = hi_q;
   assign loOut    = lo_q;
   assign busy     = (state_q == S_MUL);
   assign done     = done_q;

endmodule

// File: tb/tb_exe_alu_stage.sv
// Bench for exe_alu_stage: directed vector table, hand-written multi-cycle sequences,
// and random operations compared against a behavioural model.
`timescale 1ns/1ps
module tb_exe_alu_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pcOut = '0, regAOut = '0, regBOut = '0, expBitOut = '0;
   logic        aluSrcA = 1'b0;
   logic [1:0]  aluSrcB = '0;
   logic [3:0]  aluOp = '0;
   logic        aluEn = 1'b0;
   logic [31:0] aluOut, hiOut, loOut;
   logic        zeroFlag, busy, done;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [31:0] m_alu, m_hi, m_lo;
   logic        m_zero;

   exe_alu_stage #(.WIDTH(32), .MUL_STEPS(32)) dut (
      .clk(clk), .rst(rst), .pcOut(pcOut), .regAOut(regAOut), .regBOut(regBOut),
      .expBitOut(expBitOut), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
      .aluEn(aluEn), .aluOut(aluOut), .zeroFlag(zeroFlag), .hiOut(hiOut),
      .loOut(loOut), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sa;
      logic [1:0]  sb;
      logic [3:0]  op;
      logic [31:0] pc, a, b, imm;
      logic [31:0] exp;
      logic        ez;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] ref_single(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [63:0] ext;
      int sh;
      sh = int'(a[4:0]);
      ext = {{32{b[31]}}, b} >> sh;
      case (op)
         0:  return a + b;
         1:  return a - b;
         2:  return a & b;
         3:  return a | b;
         4:  return a ^ b;
         5:  return ~(a | b);
         6:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         7:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
         8:  return b * (32'd1 << sh);
         9:  return b / (32'd1 << sh);
         10: return ext[31:0];
         11: return b * 32'h10000;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_apply(input logic sa, input logic [1:0] sb, input logic [3:0] op,
                              input logic [31:0] pc, a, b, imm);
      logic [31:0] oa, ob, r;
      logic [63:0] prod;
      oa = sa ? a : pc;
      case (sb)
         0: ob = b;
         1: ob = 32'd4;
         2: ob = imm;
         default: ob = imm * 4;
      endcase
      if (op == 4'd12) begin
         prod = {32'd0, oa} * {32'd0, ob};
         m_hi = prod[63:32];
         m_lo = prod[31:0];
         m_alu = m_lo;
      end else begin
         r = ref_single(op, oa, ob);
         m_alu = r;
         m_zero = (r == 0);
      end
   endtask

   task automatic drive(input logic sa, input logic [1:0] sb, input logic [3:0] op,
                        input logic [31:0] pc, a, b, imm);
      aluSrcA = sa; aluSrcB = sb; aluOp = op;
      pcOut = pc; regAOut = a; regBOut = b; expBitOut = imm;
   endtask

   // Issues one request and waits (bounded) for done; cyc = edges after the accept edge.
   task automatic do_op(input logic sa, input logic [1:0] sb, input logic [3:0] op,
                        input logic [31:0] pc, a, b, imm, output int cyc, output int bcnt);
      @(negedge clk);
      drive(sa, sb, op, pc, a, b, imm);
      aluEn = 1'b1;
      @(posedge clk);
      #1 aluEn = 1'b0;
      cyc = 0;
      bcnt = busy ? 1 : 0;
      while (done !== 1'b1 && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         if (busy) bcnt++;
      end
   endtask

   task automatic check_all(input string name);
      check({name, ".alu"}, aluOut, m_alu);
      check({name, ".zero"}, zeroFlag, m_zero);
      check({name, ".hi"}, hiOut, m_hi);
      check({name, ".lo"}, loOut, m_lo);
      check({name, ".done"}, done, 1'b1);
   endtask

   initial begin
      int cyc, bcnt, saw_done;
      logic sa;
      logic [1:0] sb;
      logic [3:0] op;
      logic [31:0] pc, a, b, imm;

      tbl.push_back('{1'b0, 2'd3, 4'd0,  32'h100, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h000000FC, 1'b0});
      tbl.push_back('{1'b1, 2'd0, 4'd1,  32'h0,   32'h12345678, 32'h12345678, 32'h0,        32'h00000000, 1'b1});
      tbl.push_back('{1'b1, 2'd0, 4'd6,  32'h0,   32'hFFFFFFFF, 32'h1,        32'h0,        32'h00000001, 1'b0});
      tbl.push_back('{1'b1, 2'd0, 4'd7,  32'h0,   32'hFFFFFFFF, 32'h1,        32'h0,        32'h00000000, 1'b1});
      tbl.push_back('{1'b1, 2'd0, 4'd10, 32'h0,   32'h4,        32'h80000000, 32'h0,        32'hF8000000, 1'b0});
      tbl.push_back('{1'b1, 2'd0, 4'd8,  32'h0,   32'd31,       32'h1,        32'h0,        32'h80000000, 1'b0});
      tbl.push_back('{1'b1, 2'd0, 4'd9,  32'h0,   32'h4,        32'h80000000, 32'h0,        32'h08000000, 1'b0});
      tbl.push_back('{1'b1, 2'd0, 4'd2,  32'h0,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'hF000F000, 1'b0});
      tbl.push_back('{1'b1, 2'd0, 4'd3,  32'h0,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'hFFF0FFF0, 1'b0});
      tbl.push_back('{1'b1, 2'd0, 4'd4,  32'h0,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h0FF00FF0, 1'b0});
      tbl.push_back('{1'b1, 2'd0, 4'd5,  32'h0,   32'h0,        32'h0,        32'h0,        32'hFFFFFFFF, 1'b0});
      tbl.push_back('{1'b0, 2'd2, 4'd11, 32'h0,   32'h0,        32'h0,        32'h1234,     32'h12340000, 1'b0});
      tbl.push_back('{1'b1, 2'd1, 4'd0,  32'h0,   32'hFFFFFFFC, 32'h0,        32'h0,        32'h00000000, 1'b1});
      tbl.push_back('{1'b1, 2'd0, 4'd1,  32'h0,   32'h0,        32'h1,        32'h0,        32'hFFFFFFFF, 1'b0});
      tbl.push_back('{1'b1, 2'd0, 4'd13, 32'h0,   32'h55,       32'h66,       32'h0,        32'h00000000, 1'b1});

      // Reset held for two edges with a live request.
      drive(1'b1, 2'd0, 4'd0, 32'h0, 32'h11, 32'h22, 32'h0);
      aluEn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst.alu", aluOut, 0);
      check("rst.hi", hiOut, 0);
      check("rst.lo", loOut, 0);
      check("rst.zero", zeroFlag, 0);
      check("rst.busy", busy, 0);
      check("rst.done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      aluEn = 1'b0;
      m_alu = 0; m_hi = 0; m_lo = 0; m_zero = 0;

      foreach (tbl[i]) begin
         do_op(tbl[i].sa, tbl[i].sb, tbl[i].op, tbl[i].pc, tbl[i].a, tbl[i].b, tbl[i].imm, cyc, bcnt);
         m_alu = tbl[i].exp;
         m_zero = tbl[i].ez;
         check($sformatf("tbl%0d.lat", i), cyc, 0);
         check_all($sformatf("tbl%0d", i));
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d.pulse", i), done, 0);
      end

      // MULU all-ones; zeroFlag must keep the 1 from the preceding op 13.
      do_op(1'b1, 2'd0, 4'd12, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, cyc, bcnt);
      check("mulmax.lat", cyc, 32);
      check("mulmax.busycyc", bcnt, 32);
      check("mulmax.busyend", busy, 0);
      check("mulmax.hi", hiOut, 32'hFFFFFFFE);
      check("mulmax.lo", loOut, 32'h00000001);
      check("mulmax.alu", aluOut, 32'h00000001);
      check("mulmax.zero", zeroFlag, 1'b1);
      check("mulmax.done", done, 1'b1);
      @(posedge clk);
      #1;
      check("mulmax.pulse", done, 0);
      check("mulmax.hold", aluOut, 32'h00000001);
      m_hi = 32'hFFFFFFFE; m_lo = 1; m_alu = 1;

      // MULU 3x5 with an ADD issued mid-busy, which must be dropped.
      @(negedge clk);
      drive(1'b1, 2'd0, 4'd12, 32'h0, 32'd3, 32'd5, 32'h0);
      aluEn = 1'b1;
      @(posedge clk);
      #1 aluEn = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      drive(1'b1, 2'd0, 4'd0, 32'h0, 32'd100, 32'd1, 32'h0);
      aluEn = 1'b1;
      @(posedge clk);
      #1 aluEn = 1'b0;
      check("ign.busy", busy, 1);
      check("ign.done", done, 0);
      cyc = 6;
      while (done !== 1'b1 && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("ign.lat", cyc, 32);
      check("ign.lo", loOut, 15);
      check("ign.hi", hiOut, 0);
      check("ign.alu", aluOut, 15);
      check("ign.zero", zeroFlag, m_zero);
      @(posedge clk);
      #1;
      check("ign.hold", aluOut, 15);
      check("ign.pulse", done, 0);
      m_hi = 0; m_lo = 15; m_alu = 15;

      // Back-to-back single-cycle requests, second one in the done cycle.
      @(negedge clk);
      drive(1'b1, 2'd0, 4'd0, 32'h0, 32'd5, 32'd7, 32'h0);
      aluEn = 1'b1;
      @(posedge clk);
      #1;
      check("b2b1.alu", aluOut, 12);
      check("b2b1.done", done, 1);
      @(negedge clk);
      drive(1'b1, 2'd0, 4'd1, 32'h0, 32'd5, 32'd5, 32'h0);
      @(posedge clk);
      #1 aluEn = 1'b0;
      check("b2b2.alu", aluOut, 0);
      check("b2b2.zero", zeroFlag, 1);
      check("b2b2.done", done, 1);
      @(posedge clk);
      #1;
      check("b2b.pulse", done, 0);
      m_alu = 0; m_zero = 1;

      // Random operations against the model.
      for (int i = 0; i < 120; i++) begin
         sa = 1'($urandom);
         sb = 2'($urandom);
         op = ($urandom_range(0, 5) == 0) ? 4'd12 : 4'($urandom);
         pc = $urandom; a = $urandom; b = $urandom; imm = $urandom;
         if ($urandom_range(0, 3) == 0) b = a;
         do_op(sa, sb, op, pc, a, b, imm, cyc, bcnt);
         model_apply(sa, sb, op, pc, a, b, imm);
         check($sformatf("rnd%0d.lat", i), cyc, (op == 4'd12) ? 32 : 0);
         check_all($sformatf("rnd%0d op%0d", i, op));
      end

      // Reset at step 10 of a MULU aborts it with no done.
      @(negedge clk);
      drive(1'b1, 2'd0, 4'd12, 32'h0, 32'd7, 32'd9, 32'h0);
      aluEn = 1'b1;
      @(posedge clk);
      #1 aluEn = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("abort.alu", aluOut, 0);
      check("abort.hi", hiOut, 0);
      check("abort.lo", loOut, 0);
      check("abort.zero", zeroFlag, 0);
      check("abort.busy", busy, 0);
      check("abort.done", done, 0);
      saw_done = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || busy === 1'b1) saw_done++;
      end
      check("abort.quiet", saw_done, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
